uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Captures each byte presented on the receiver's `rx_buffer` output when its `rx_int` flag rises, and stores it in a first-word-fall-through FIFO. Downstream logic (LED driver, command parser) drains the FIFO through a valid/ready handshake. Overflow is flagged rather than stalling the receiver, which cannot be back-pressured.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, ≥ 2. `AW` = log2(DEPTH), derived.
- `clk`  in  1  system clock (27 MHz on board); all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  8  received byte (UART `rx_buffer`); stable while `rx_int` is high.
- `rx_int`  in  1  UART receive-done flag; level, multi-cycle high per byte.
- `rd_valid`  out  1  FIFO non-empty; `rd_data` is valid.
- `rd_data`  out  8  head-of-FIFO byte.
- `rd_ready`  in  1  consumer accepts `rd_data` this cycle.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: at least one byte was dropped.
- `clr_overflow`  in  1  single-cycle clear of `overflow` (and `drop_cnt`).
- `drop_cnt`  out  8  dropped-byte count (see Configuration).

## Operation
- Edge detect: register `rx_int_q`; write strobe `wr = rx_int & ~rx_int_q`. Exactly one write per rising edge of `rx_int`, however long it stays high. `rx_int` must return low between bytes.
- Storage: DEPTH x 8 array with asynchronous read; `wr_ptr` and `rd_ptr` are AW+1 bits and wrap naturally; `count = wr_ptr - rd_ptr`; `full` when `count == DEPTH`.
- Pop: `pop = rd_valid & rd_ready`; advances `rd_ptr`. `rd_ready` is ignored while `rd_valid` is low.
- Push: `wr` with (`!full` or `pop`) writes `rx_data` at `wr_ptr[AW-1:0]` and advances `wr_ptr`.
- Drop: `wr` with `full` and no `pop` discards the byte. Sets `overflow` and increments `drop_cnt`, which saturates at 255.
- Clear: `clr_overflow` zeroes `overflow` and `drop_cnt`. If a drop occurs in the same cycle, the drop wins: `overflow` = 1 and `drop_cnt` = 1.
- Reset values: pointers 0, `count` 0, `rd_valid` 0, `full` 0, `overflow` 0, `drop_cnt` 0, `rd_data` = mem[0] (don't-care). `rx_int_q` resets to 1, so an `rx_int` already high at reset release is not captured.
- Reset mid-operation empties the FIFO immediately (asynchronous). Array contents are not cleared.

## Timing
- Write latency: if `rx_int` is first sampled high at edge E, `rd_valid` and `rd_data` show the byte from just after E (one cycle).
- `rd_data` changes combinationally with `rd_ptr`. After a pop at edge E, the next byte is presented immediately after E.
- Simultaneous push and pop: `count` is unchanged. When full, this does not drop and does not set `overflow`.
- Empty with `wr` and `rd_ready` both high: no pop; the byte is visible the next cycle.
- Throughput: one push and one pop per cycle. `rx_int` edges arrive at most once per ~2350 clocks at 115200 baud.

## Configuration
- `UART_RX_FIFO_DROP_CNT_EN` defined: the 8-bit saturating `drop_cnt` register is implemented as described.
- Not defined: no counter register is built; `drop_cnt` is tied to 0. `overflow` behaviour is unchanged.

## Test plan
- Reset with `rx_int` = 1 held across release, then `rx_int` 1->0->1 with `rx_data` = 0x41 -> exactly one entry, `rd_data` = 0x41, `count` = 1.
- `rx_int` held high 100 cycles with `rx_data` = 0x5A -> `count` = 1 (single write).
- DEPTH = 16: push 0x00..0x0F, `rd_ready` = 0 -> `full` = 1. Push 0x10 and 0x11 -> `overflow` = 1, `drop_cnt` = 2 (0 without macro). Drain -> 0x00..0x0F in order, then `rd_valid` = 0.
- Full FIFO, `rx_int` edge with 0x77 in the same cycle as a pop -> no overflow, `count` stays 16, 0x77 is read last.
- `clr_overflow` pulsed in the same cycle as a drop -> `overflow` = 1, `drop_cnt` = 1. Pulsed alone next cycle -> both 0.
- Push 5 bytes, wrap pointers with 20 push/pop pairs, assert `rst` = 0 mid-stream -> `count` = 0 and `rd_valid` = 0 without waiting for a clock.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte FIFO behind the UART receiver. Each rising
// edge of rx_int captures rx_data; consumer drains via rd_valid/rd_ready.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   rx_data      received byte, stable while rx_int is high
//   rx_int       receive-done level flag, one byte per rising edge
//   rd_valid     FIFO non-empty, rd_data valid
//   rd_data      head-of-FIFO byte (combinational from read pointer)
//   rd_ready     consumer takes rd_data this cycle
//   count        occupancy 0..DEPTH
//   full         count == DEPTH
//   overflow     sticky, a byte was dropped
//   clr_overflow single-cycle clear of overflow and drop_cnt
//   drop_cnt     saturating dropped-byte count
//
// Build option: define UART_RX_FIFO_DROP_CNT_EN to build the drop
// counter register; otherwise drop_cnt is tied to zero.

module uart_rx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_int,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  input  logic          rd_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  input  logic          clr_overflow,
  output logic [7:0]    drop_cnt
);

  localparam logic [AW:0] L_FULL = DEPTH[AW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_rx_int_q;
  logic          r_overflow;

  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // Rising-edge detect on the receive flag.
  // Resets high so a flag already asserted at
  // reset release is not taken as a new byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_int_q <= 1'b1;
    end else begin
      r_rx_int_q <= rx_int;
    end
  end

  assign w_wr = rx_int & ~r_rx_int_q;

  // Pointers carry one extra bit so full and
  // empty are distinguished by the difference.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == L_FULL);
  assign w_empty = (w_count == '0);

  assign w_pop  = ~w_empty & rd_ready;

  // A pop in the same cycle frees the slot,
  // so a full FIFO still accepts the byte.
  assign w_push = w_wr & (~w_full | w_pop);
  assign w_drop = w_wr & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; contents behind the
  // pointers are never observed as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= rx_data;
    end
  end

  // Sticky overflow; a drop outranks a clear
  // arriving in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating count of discarded bytes. A drop
  // coinciding with a clear restarts at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (clr_overflow) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_overflow) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

  assign rd_valid = ~w_empty;
  assign rd_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign count    = w_count;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus randomized bench for uart_rx_fifo.
// Queue-based reference model; per-cycle monitor checks DUT outputs.

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
`ifdef UART_RX_FIFO_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_int;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic [AW:0] count;
  logic        full;
  logic        overflow;
  logic        clr_overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_int       (rx_int),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int n);
    return CNT_EN ? n : 0;
  endfunction

  // Reference model: a byte queue plus overflow state.
  byte unsigned m_q[$];
  bit           m_prev;
  bit           m_ovf;
  int           m_cnt;

  always @(negedge clk) begin
    bit pop;
    bit wr;
    if (!rst) begin
      chk("rst_count", int'(count), 0);
      chk("rst_valid", int'(rd_valid), 0);
      m_q.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end else begin
      chk("m_valid", int'(rd_valid), int'(m_q.size() != 0));
      chk("m_count", int'(count), m_q.size());
      chk("m_full", int'(full), int'(m_q.size() == DEPTH));
      chk("m_ovf", int'(overflow), int'(m_ovf));
      chk("m_drop", int'(drop_cnt), exp_cnt(m_cnt));
      if (m_q.size() != 0) chk("m_data", int'(rd_data), int'(m_q[0]));
      pop = (m_q.size() != 0) && rd_ready;
      wr  = rx_int && !m_prev;
      if (wr && !(m_q.size() < DEPTH || pop)) begin
        m_ovf = 1'b1;
        m_cnt = clr_overflow ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
      end else if (clr_overflow) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (wr && (m_q.size() < DEPTH)) m_q.push_back(rx_data);
      m_prev = rx_int;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    rx_data = b;
    rx_int  = 1'b1;
    tick();
    rx_int  = 1'b0;
    tick();
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b [DEPTH];
    rst          = 1'b0;
    rx_int       = 1'b1;
    rx_data      = 8'h00;
    rd_ready     = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) tick();
    chk("reset_count", int'(count), 0);
    chk("reset_valid", int'(rd_valid), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_ovf", int'(overflow), 0);
    chk("reset_drop", int'(drop_cnt), 0);

    // rx_int high across reset release is ignored
    rst = 1'b1;
    repeat (3) tick();
    chk("held_no_write", int'(count), 0);
    rx_int = 1'b0;
    tick();
    rx_data = 8'h41;
    rx_int  = 1'b1;
    tick();
    chk("lat_valid", int'(rd_valid), 1);
    chk("lat_data", int'(rd_data), 8'h41);
    chk("lat_count", int'(count), 1);
    rx_int = 1'b0;
    drain();

    // long rx_int pulse writes once
    rx_data = 8'h5A;
    rx_int  = 1'b1;
    repeat (100) tick();
    chk("long_pulse_count", int'(count), 1);
    rx_int = 1'b0;
    tick();
    chk("long_pulse_data", int'(rd_data), 8'h5A);
    drain();

    // fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) wr_byte(8'(i));
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), DEPTH);
    wr_byte(8'h10);
    wr_byte(8'h11);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_drop", int'(drop_cnt), exp_cnt(2));
    chk("ovf_count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", int'(rd_data), i);
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_empty", int'(rd_valid), 0);

    // push and pop together while full
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_ovf", int'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) wr_byte(8'(8'h20 + i));
    rx_data  = 8'h77;
    rx_int   = 1'b1;
    rd_ready = 1'b1;
    tick();
    rx_int   = 1'b0;
    rd_ready = 1'b0;
    chk("pp_no_ovf", int'(overflow), 0);
    chk("pp_count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH - 1; i++) exp_b[i] = 8'(8'h21 + i);
    exp_b[DEPTH-1] = 8'h77;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      chk("pp_order", int'(rd_data), int'(exp_b[i]));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;

    // clear coinciding with a drop
    for (int i = 0; i < DEPTH; i++) wr_byte(8'(8'h30 + i));
    wr_byte(8'h99);
    chk("pre_clr_drop", int'(drop_cnt), exp_cnt(1));
    rx_data      = 8'hAA;
    rx_int       = 1'b1;
    clr_overflow = 1'b1;
    tick();
    rx_int       = 1'b0;
    clr_overflow = 1'b0;
    chk("clr_drop_ovf", int'(overflow), 1);
    chk("clr_drop_cnt", int'(drop_cnt), exp_cnt(1));
    tick();
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_alone_ovf", int'(overflow), 0);
    chk("clr_alone_cnt", int'(drop_cnt), 0);
    drain();

    // wrap pointers, then async reset mid-stream
    for (int i = 0; i < 5; i++) wr_byte(8'(8'h50 + i));
    for (int i = 0; i < 20; i++) begin
      rx_data  = 8'(8'h60 + i);
      rx_int   = 1'b1;
      rd_ready = 1'b1;
      tick();
      rx_int   = 1'b0;
      rd_ready = 1'b0;
      tick();
    end
    chk("wrap_count", int'(count), 5);
    rx_data  = 8'hC3;
    rx_int   = 1'b1;
    rd_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_valid", int'(rd_valid), 0);
    rx_int   = 1'b0;
    rd_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // randomized traffic, slow then fast consumer
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        if (rx_int) begin
          rx_int = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 1) == 1) begin
          rx_data = 8'($urandom);
          rx_int  = 1'b1;
        end
        rd_ready = (ph == 0) ? ($urandom_range(0, 3) == 0)
                             : ($urandom_range(0, 3) != 0);
        clr_overflow = ($urandom_range(0, 63) == 0);
        tick();
      end
    end
    rx_int       = 1'b0;
    clr_overflow = 1'b0;
    drain();
    chk("final_empty", int'(rd_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
